// File: rtl/axi_sequencer_pkg.sv
// Shared encodings for the AXI read/write sequencers (master and slave ends).
// Each sequencer steps through address, system-side and data phases in turn.
package axi_sequencer_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        DO_ADDR = 2'd0,
        DO_SYS  = 2'd1,
        DO_DATA = 2'd2
    } seq_state_t;

endpackage

// File: rtl/axi_beat_counter.sv
// Down-counter of burst beats remaining after the current beat.
// It saturates at zero so an all-ones ARLEN never wraps.
module axi_beat_counter #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_value,
    input  logic                 decrement,
    output logic [LEN_WIDTH-1:0] count,
    output logic                 is_zero
);

    logic [LEN_WIDTH-1:0] count_q = '0;

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (decrement && (count_q != '0)) begin
            count_q <= count_q - LEN_WIDTH'(1);
        end
    end

    assign count   = count_q;
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/slave_axi_read_sequencer.sv
// Slave-side AXI read sequencer: accepts one AR, then alternates a system
// fetch and an R beat per burst beat until the final beat is handed over.
module slave_axi_read_sequencer
    import axi_sequencer_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    output logic                 ar_control_enable,
    input  logic                 ar_control_done,
    input  logic [LEN_WIDTH-1:0] ar_len,
    output logic                 sys_read_enable,
    input  logic                 sys_read_done,
    output logic                 r_control_enable,
    input  logic                 r_control_done,
    output logic                 r_last,
    output logic                 busy
);

    seq_state_t           state = DO_ADDR;
    seq_state_t           next_state;
    logic                 ar_done;
    logic                 sys_done;
    logic                 r_done;
    logic [LEN_WIDTH-1:0] beats_left;
    logic                 beats_zero;

    // A done only counts while its own phase is active; stray dones are dropped.
    assign ar_done  = (state == DO_ADDR) && ar_control_done;
    assign sys_done = (state == DO_SYS)  && sys_read_done;
    assign r_done   = (state == DO_DATA) && r_control_done;

    axi_beat_counter #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_beat_counter (
        .clock      (clock),
        .clear      (clear),
        .load       (ar_done),
        .load_value (ar_len),
        .decrement  (r_done && (beats_left != '0)),
        .count      (beats_left),
        .is_zero    (beats_zero)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= DO_ADDR;
        end else begin
            state <= next_state;
        end
    end

    // The unused encoding falls back to DO_ADDR on the next edge.
    always_comb begin
        next_state = state;
        case (state)
            DO_ADDR: if (ar_done)  next_state = DO_SYS;
            DO_SYS:  if (sys_done) next_state = DO_DATA;
            DO_DATA: if (r_done)   next_state = beats_zero ? DO_ADDR : DO_SYS;
            default:               next_state = DO_ADDR;
        endcase
    end

    assign ar_control_enable = (state == DO_ADDR);
    assign sys_read_enable   = (state == DO_SYS);
    assign r_control_enable  = (state == DO_DATA);
    assign r_last            = (state == DO_DATA) && beats_zero;
    assign busy              = (state != DO_ADDR);

endmodule

// File: tb/tb_slave_axi_read_sequencer.sv
// Self-checking bench for slave_axi_read_sequencer: vector table, corner-case
// sequences and random traffic against a beat-counting transaction model.
module tb_slave_axi_read_sequencer;

    localparam int LEN_WIDTH = 8;

    logic                 clock = 1'b0;
    logic                 clear = 1'b1;
    logic                 ar_control_enable;
    logic                 ar_control_done = 1'b0;
    logic [LEN_WIDTH-1:0] ar_len = '0;
    logic                 sys_read_enable;
    logic                 sys_read_done = 1'b0;
    logic                 r_control_enable;
    logic                 r_control_done = 1'b0;
    logic                 r_last;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = waiting for address, 1 = fetching, 2 = responding;
    // pending = R beats still owed in the burst, counting the current one.
    int model_phase   = 0;
    int model_pending = 0;

    typedef struct {
        logic                 clr;
        logic                 ar;
        logic                 sys;
        logic                 r;
        logic [LEN_WIDTH-1:0] len;
        logic [4:0]           exp;   // {ar_en, sys_en, r_en, r_last, busy}
    } vec_t;

    vec_t vecs[15];

    slave_axi_read_sequencer #(
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clock             (clock),
        .clear             (clear),
        .ar_control_enable (ar_control_enable),
        .ar_control_done   (ar_control_done),
        .ar_len            (ar_len),
        .sys_read_enable   (sys_read_enable),
        .sys_read_done     (sys_read_done),
        .r_control_enable  (r_control_enable),
        .r_control_done    (r_control_done),
        .r_last            (r_last),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] model_outputs();
        return {model_phase == 0, model_phase == 1, model_phase == 2,
                (model_phase == 2) && (model_pending == 1), model_phase != 0};
    endfunction

    function automatic logic [4:0] dut_outputs();
        return {ar_control_enable, sys_read_enable, r_control_enable, r_last, busy};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, then settle.
    task automatic applyStimulus(input logic c, input logic a, input logic s,
                                 input logic r, input logic [LEN_WIDTH-1:0] l);
        clear = c; ar_control_done = a; sys_read_done = s; r_control_done = r; ar_len = l;
        @(posedge clock);
        if (c) begin
            model_phase = 0;
            model_pending = 0;
        end else begin
            case (model_phase)
                0: if (a) begin model_phase = 1; model_pending = int'(l) + 1; end
                1: if (s) model_phase = 2;
                default: if (r) begin
                    model_pending = model_pending - 1;
                    model_phase = (model_pending == 0) ? 0 : 1;
                end
            endcase
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expected);
        total++;
        if (dut_outputs() !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b ({ar_en,sys_en,r_en,r_last,busy})",
                     name, dut_outputs(), expected);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Keep every done high from DO_ADDR until the sequencer returns there.
    task automatic runBurst(input string name, input logic [LEN_WIDTH-1:0] len,
                            input int bound, output int cycles, output int beats,
                            output int lasts, output int last_beat);
        cycles = 0; beats = 0; lasts = 0; last_beat = 0;
        do begin
            if (r_control_enable) begin
                beats++;
                if (r_last) begin lasts++; last_beat = beats; end
            end
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, len);
            cycles++;
            checkOutput(name, model_outputs());
        end while (!ar_control_enable && cycles < bound);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int cycles, beats, lasts, last_beat;

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 5'b10000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 5'b10000};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 5'b10000};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 5'b10000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 5'b01001};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 5'b00111};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 5'b10000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 5'b01001};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 5'b01001};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 5'b00101};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 5'b00101};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 5'b01001};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 5'b00111};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 5'b00111};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 5'b10000};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].ar, vecs[i].sys, vecs[i].r, vecs[i].len);
            checkOutput($sformatf("vector%0d", i), vecs[i].exp);
        end

        runBurst("burst4", 8'd3, 40, cycles, beats, lasts, last_beat);
        checkValue("burst4_cycles", cycles, 9);
        checkValue("burst4_beats", beats, 4);
        checkValue("burst4_lasts", lasts, 1);
        checkValue("burst4_last_beat", last_beat, 4);

        runBurst("burst256", 8'hFF, 600, cycles, beats, lasts, last_beat);
        checkValue("burst256_cycles", cycles, 513);
        checkValue("burst256_beats", beats, 256);
        checkValue("burst256_last_beat", last_beat, 256);

        // Stall the system fetch of each of two beats for five cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        beats = 0; lasts = 0; last_beat = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
                checkOutput("stall_hold", 5'b01001);
            end
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            checkOutput("stall_release", model_outputs());
            if (r_control_enable) begin
                beats++;
                if (r_last) begin lasts++; last_beat = beats; end
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        end
        checkValue("stall_beats", beats, 2);
        checkValue("stall_last_beat", last_beat, 2);
        checkValue("stall_lasts", lasts, 1);
        checkOutput("stall_end", 5'b10000);

        // Clear while beat 3 of an 8-beat burst is on R, then a single read.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("beat3_on_r", 5'b00101);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        checkOutput("midclear", 5'b10000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("after_clear_sys", 5'b01001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        checkOutput("after_clear_last", 5'b00111);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        checkOutput("after_clear_idle", 5'b10000);

        for (int n = 0; n < 3000; n++) begin
            logic [LEN_WIDTH-1:0] len;
            len = ($urandom_range(0, 15) == 0) ? 8'hFF : LEN_WIDTH'($urandom_range(0, 5));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, len);
            checkOutput("random", model_outputs());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
